// File: rtl/fsm_seq_driver_pkg.sv
// Shared codes for the control-FSM stimulus driver and its route table.
// The FSM_SEQ_RESET_EN macro adds the RST driver state.
package fsm_seq_pkg;

    typedef enum logic [2:0] {
        INITIAL = 3'd0,
        S1      = 3'd1,
        S2      = 3'd2,
        S3      = 3'd3,
        S4      = 3'd4
    } ctl_state_e;

`ifdef FSM_SEQ_RESET_EN
    typedef enum logic [1:0] {
        DRV_IDLE = 2'd0,
        DRV_RUN  = 2'd1,
        DRV_RESP = 2'd2,
        DRV_RST  = 2'd3
    } drv_state_e;
`else
    typedef enum logic [1:0] {
        DRV_IDLE = 2'd0,
        DRV_RUN  = 2'd1,
        DRV_RESP = 2'd2
    } drv_state_e;
`endif

    localparam logic [2:0] MAX_TARGET = 3'd4;

endpackage

// File: rtl/fsm_seq_driver_if.sv
// Command/response handshake bundle between a requester and fsm_seq_driver.
interface fsm_seq_driver_if #(
    parameter int CNT_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_target;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_ok;
    logic [CNT_W-1:0] rsp_steps;

    modport master (
        output cmd_valid, cmd_target, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ok, rsp_steps
    );

    modport slave (
        input  cmd_valid, cmd_target, rsp_ready,
        output cmd_ready, rsp_valid, rsp_ok, rsp_steps
    );

endinterface

// File: rtl/fsm_seq_driver_route.sv
// Combinational route table: picks the (a, b) that moves the control FSM
// one hop closer to the target from its current status.
module fsm_seq_route
    import fsm_seq_pkg::*;
(
    input  logic [2:0] status,
    input  logic [2:0] target,
    output logic       route_a,
    output logic       route_b
);

    always_comb begin
        route_a = 1'b0;
        route_b = 1'b0;
        case (status)
            INITIAL: begin
                route_a = 1'b0;
                route_b = 1'b0;
            end
            S1: begin
                route_a = 1'b1;
                route_b = 1'b1;
            end
            S2: begin
                route_a = 1'b1;
                route_b = 1'b0;
            end
            // From S3 the only exits are S4 (a&!b) or back round via INITIAL (!a&b).
            S3: begin
                if (target == S4) begin
                    route_a = 1'b1;
                    route_b = 1'b0;
                end else begin
                    route_a = 1'b0;
                    route_b = 1'b1;
                end
            end
            default: begin
                route_a = 1'b0;
                route_b = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fsm_seq_driver.sv
// Drives the control FSM's a/b inputs until its status matches a commanded target.
// Define FSM_SEQ_RESET_EN to add the fsm_reset port and recovery from sticky state 4.
module fsm_seq_driver
    import fsm_seq_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fsm_seq_driver_if.slave       bus,
    input  logic [2:0]            status,
    output logic                  drive_a,
    output logic                  drive_b
`ifdef FSM_SEQ_RESET_EN
    ,
    output logic                  fsm_reset
`endif
);

    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

    drv_state_e       state_q, state_d;
    logic [2:0]       target_q, target_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [CNT_W-1:0] rsp_steps_q, rsp_steps_d;

    logic route_a;
    logic route_b;

    fsm_seq_route u_route (
        .status  (status),
        .target  (target_q),
        .route_a (route_a),
        .route_b (route_b)
    );

    // Drives are Mealy on status so each step reacts in the same cycle.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        steps_d     = steps_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_steps_d = rsp_steps_q;
        drive_a     = 1'b0;
        drive_b     = 1'b0;
        case (state_q)
            DRV_IDLE: begin
                if (bus.cmd_valid) begin
                    target_d = bus.cmd_target;
                    steps_d  = '0;
                    if (bus.cmd_target > MAX_TARGET) begin
                        state_d     = DRV_RESP;
                        rsp_ok_d    = 1'b0;
                        rsp_steps_d = '0;
                    end else begin
                        state_d = DRV_RUN;
                    end
                end
            end
            DRV_RUN: begin
                if (status == target_q) begin
                    state_d     = DRV_RESP;
                    rsp_ok_d    = 1'b1;
                    rsp_steps_d = steps_q;
                end else if (status == S4) begin
`ifdef FSM_SEQ_RESET_EN
                    state_d     = DRV_RST;
`else
                    state_d     = DRV_RESP;
                    rsp_ok_d    = 1'b0;
                    rsp_steps_d = steps_q;
`endif
                end else if (steps_q == STEP_LIMIT) begin
                    state_d     = DRV_RESP;
                    rsp_ok_d    = 1'b0;
                    rsp_steps_d = steps_q;
                end else begin
                    drive_a = route_a;
                    drive_b = route_b;
                    steps_d = steps_q + CNT_W'(1);
                end
            end
`ifdef FSM_SEQ_RESET_EN
            DRV_RST: begin
                state_d = DRV_RUN;
                if (steps_q != STEP_LIMIT) begin
                    steps_d = steps_q + CNT_W'(1);
                end
            end
`endif
            DRV_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = DRV_IDLE;
                end
            end
            default: begin
                state_d = DRV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= DRV_IDLE;
            target_q    <= '0;
            steps_q     <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_steps_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            steps_q     <= steps_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_steps_q <= rsp_steps_d;
        end
    end

    assign bus.cmd_ready = (state_q == DRV_IDLE);
    assign bus.rsp_valid = (state_q == DRV_RESP);
    assign bus.rsp_ok    = rsp_ok_q;
    assign bus.rsp_steps = rsp_steps_q;

`ifdef FSM_SEQ_RESET_EN
    assign fsm_reset = (state_q == DRV_RST);
`endif

endmodule

// File: doc/fsm_seq_driver.md
# fsm_seq_driver

Stimulus driver for the basic five-state control FSM. It accepts a target-state command, reads the FSM's 3-bit `status`, and drives the FSM's `a`/`b` inputs cycle by cycle until the FSM reaches the target. It then returns a response with a pass/fail flag and the number of steps taken. It sits opposite the control FSM on the same clock: its `drive_a`/`drive_b` feed the FSM's `a`/`b`, and the FSM's `status` feeds back in.

## Interface
- `MAX_STEPS`, default 8: step budget per command before timeout.
- `CNT_W`, default 4: width of the step counter and `rsp_steps`; must satisfy 2^CNT_W > MAX_STEPS.

- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  driver idle, command accepted when `cmd_valid & cmd_ready`.
- `cmd_target`  in  3  target FSM state; valid values are 0..4.
- `rsp_valid`  out  1  response pending.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_ok`  out  1  1 = target reached; 0 = error or timeout.
- `rsp_steps`  out  CNT_W  number of steps used.
- `status`  in  3  controlled FSM's status (registered in the FSM).
- `drive_a`  out  1  to FSM input `a`.
- `drive_b`  out  1  to FSM input `b`.
- `fsm_reset`  out  1  one-cycle reset pulse to the FSM; present only with `FSM_SEQ_RESET_EN`.

## Operation
- Controlled FSM behaviour (the routing basis):
  - 0 goes to 1 unconditionally.
  - 1 goes to 2 on a&b.
  - 2 goes to 3 on a.
  - 3 goes to 0 on !a&b, and to 4 on a&!b.
  - 4 is sticky until reset.
  - Codes 5..7 go to 0.
  - Any state not listed as moving holds.
- Driver states: IDLE, RUN, RST, RESP.
- IDLE: `cmd_ready`=1 and drives are 0. On accept, latch the target and clear the step counter.
  - If `cmd_target` > 4: go to RESP with ok=0, steps=0.
  - Otherwise: go to RUN.
- RUN is evaluated every cycle, first match wins:
  1. `status` == target: go to RESP with ok=1; drives are 0.
  2. `status` == 4 (target ≠ 4): with the macro, go to RST; without it, go to RESP with ok=0.
  3. steps == MAX_STEPS: go to RESP with ok=0 (timeout).
  4. Otherwise: drive the route value and increment steps.
- Route table (`status` s, target t), combinational, so it is Mealy on `status` with no extra lag:
  - s=0: a=0, b=0.
  - s=1: a=1, b=1.
  - s=2: a=1, b=0.
  - s=3, t=4: a=1, b=0.
  - s=3, t≠4: a=0, b=1.
  - s=5..7: a=0, b=0.
- Holding at target: a=b=0 holds states 1, 2 and 3. State 0 cannot hold; ok=1 for target 0 means 0 was observed.
- RST: assert `fsm_reset` for one cycle, increment steps, return to RUN.
- RESP:
  - `rsp_valid`=1; `rsp_ok` and `rsp_steps` are held stable until `rsp_ready`.
  - Drives are 0.
  - Returns to IDLE the cycle after the handshake.
  - `cmd_ready`=0 while in RESP.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_ok`=0, `rsp_steps`=0, `drive_a`=0, `drive_b`=0, `fsm_reset`=0.
- Latency: accept at cycle N, first RUN evaluation at N+1. A k-step path responds at N+1+k.
- Reference step counts:
  - 0→4: 4 steps.
  - 3→2: 3 steps.
  - 2→1: 3 steps.
  - Target already reached: 0 steps, `rsp_valid` at N+1.
- Step counter saturates at MAX_STEPS.
- Back-to-back commands: the earliest next accept is the cycle after the response handshake.
- `reset` mid-command: immediate return to the reset values. The in-flight command is dropped and no response is issued.

## Configuration
- `FSM_SEQ_RESET_EN`: builds the `fsm_reset` port and the RST state. A command that finds the FSM in 4 with target ≠ 4 resets the FSM and continues.
- Without the macro: no port and no RST state; that case returns ok=0 with the current step count.

## Structure
- Package `fsm_seq_pkg` holds:
  - the controlled FSM's state codes (INITIAL=0 .. S4=4);
  - the driver state enum;
  - `MAX_TARGET`=4.
- Sub-module `fsm_seq_route`: purely combinational route table, (`status`, target) → (a, b).
- Top level holds the handshake FSM, the step counter and the response registers.

## Test plan
- FSM at 0, target 4 → drive sequence (0,0), (1,1), (1,0), (1,0); response ok=1, steps=4.
- FSM holding at 3, target 2 → drives (0,1), (0,0), (1,1); response ok=1, steps=3.
- FSM at 2, target 2 → response at N+1, ok=1, steps=0, drives 0.
- Target 6 → response ok=0, steps=0; FSM untouched.
- FSM in 4, target 1:
  - with macro: `fsm_reset` pulse, then ok=1, steps=2;
  - without macro: ok=0, steps=0.
- `rsp_ready` held low 5 cycles → response fields stable and `cmd_ready`=0 throughout. Separately, assert `reset` during RUN → outputs return to the reset values the same cycle and no `rsp_valid` follows.
